regfile_scoreboard: RTL and testbench
=====================================

// Module: regfile_scoreboard
// PURPOSE
//   Parametrised general-purpose register file with write-to-read bypass and a per-register
//   busy scoreboard. Sits between decode and execute/writeback of the processor: decode
//   reads two operands and reserves a destination; writeback writes the result and releases it.
//   Successor to the fixed 4x4 register file, with width, depth and register-zero mode generalised.
// PARAMETERS
//   DATA_W    4   register width in bits
//   ADDR_W    2   register address width
//   NREGS     4   implemented registers (<= 2**ADDR_W); higher addresses are unimplemented
//   ZERO_REG  0   1: register 0 reads as 0, ignores writes, never busy
//   BYPASS    1   1: same-cycle write data forwarded to read ports; 0: read old contents
// PORTS
//   clk          in   1        clock, all state updates on rising edge
//   reset        in   1        synchronous, active-high
//   wr_en        in   1        writeback strobe
//   wr_addr      in   ADDR_W   writeback destination
//   wr_data      in   DATA_W   writeback value
//   rd_addr1     in   ADDR_W   operand 1 address
//   rd_addr2     in   ADDR_W   operand 2 address
//   rd_data1     out  DATA_W   operand 1 value (combinational)
//   rd_data2     out  DATA_W   operand 2 value (combinational)
//   rd_busy1     out  1        operand 1 has an outstanding producer
//   rd_busy2     out  1        operand 2 has an outstanding producer
//   issue_en     in   1        request to reserve issue_addr as a destination
//   issue_addr   in   ADDR_W   destination to reserve
//   issue_ready  out  1        reservation would be accepted this cycle
// BEHAVIOUR
//   - Reset (sync, active-high): all registers <= 0, all busy bits <= 0; wr_en/issue_en ignored
//     in the reset cycle. After reset: rd_data* = 0, rd_busy* = 0, issue_ready = 1.
//   - Write: on posedge with wr_en, reg[wr_addr] <= wr_data (full DATA_W, no padding/truncation).
//   - Read: rd_dataN = reg[rd_addrN], zero latency. If BYPASS and wr_en and wr_addr == rd_addrN
//     (and write is legal), rd_dataN = wr_data in the same cycle.
//   - Scoreboard: busy[r] set on posedge when issue_en && issue_ready && issue_addr == r;
//     cleared on posedge when wr_en && wr_addr == r. Same address both events: set wins (busy = 1).
//   - rd_busyN = busy[rd_addrN] & ~(wr_en & wr_addr == rd_addrN) when BYPASS, else busy[rd_addrN].
//   - issue_ready = ~busy[issue_addr] | (wr_en & wr_addr == issue_addr); WAW to an unreleased
//     register is refused. issue_en while !issue_ready: no state change; requester must hold/retry.
//   - issue_ready is independent of issue_en (no combinational loop through issue_en).
//   - Writes to a non-busy register are legal and update the value (busy stays 0).
//   - ZERO_REG=1: address 0 reads 0, never bypasses, rd_busy=0, issue_ready=1, issue is a no-op.
//   - Address >= NREGS: reads return 0 / busy 0; writes and issues ignored; issue_ready = 1.
//   - Reset mid-operation: all reservations dropped; writebacks of pre-reset producers arriving
//     later are plain writes.
// TESTING (DATA_W=4, ADDR_W=2, NREGS=4 unless stated)
//   - reset, then read all 4 addrs -> every rd_data = 4'h0, rd_busy = 0, issue_ready = 1.
//   - wr r2=4'hA; next cycle rd_addr1=2 -> 4'hA; same-cycle wr r3=4'h5 with rd_addr2=3 ->
//     rd_data2=4'h5 (BYPASS=1), 4'h0 (BYPASS=0).
//   - issue r1 -> rd_busy1=1 at rd_addr1=1, issue r1 again -> issue_ready=0, no change; wr r1=4'h7
//     -> rd_busy1=0 in write cycle (BYPASS=1), reads 4'h7.
//   - busy r1; same cycle wr r1=4'h3 and issue r1 -> r1=4'h3, busy r1 stays 1.
//   - ZERO_REG=1: wr r0=4'hF, issue r0 -> rd r0 = 4'h0, rd_busy=0; r1..r3 unaffected.
//   - busy r0..r3, write r2=4'h9, assert reset -> all regs 0, all busy 0; NREGS=3: wr r3 ignored, reads 0.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Parametrised register file with same-cycle write bypass and a per-register busy scoreboard.
// Decode reads operands and reserves destinations; writeback writes results and releases them.
module regfile_scoreboard #(
    parameter int DATA_W   = 4,
    parameter int ADDR_W   = 2,
    parameter int NREGS    = 4,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_busy1,
    output logic              rd_busy2,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic              issue_ready
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;

    // A register is "real" when implemented and not the hardwired zero register;
    // every other address reads 0, is never busy and swallows writes/issues.
    function automatic logic is_real(input logic [ADDR_W-1:0] a);
        return (int'(a) < NREGS) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    logic wr_legal;
    logic wr_hit1, wr_hit2, wr_hit_iss;
    logic issue_take;

    assign wr_legal   = wr_en && is_real(wr_addr);
    assign wr_hit1    = wr_legal && (wr_addr == rd_addr1);
    assign wr_hit2    = wr_legal && (wr_addr == rd_addr2);
    assign wr_hit_iss = wr_legal && (wr_addr == issue_addr);

    always_comb begin
        rd_data1 = '0;
        rd_busy1 = 1'b0;
        if (is_real(rd_addr1)) begin
            rd_data1 = ((BYPASS != 0) && wr_hit1) ? wr_data : regs_q[rd_addr1];
            rd_busy1 = busy_q[rd_addr1] && !((BYPASS != 0) && wr_hit1);
        end
    end

    always_comb begin
        rd_data2 = '0;
        rd_busy2 = 1'b0;
        if (is_real(rd_addr2)) begin
            rd_data2 = ((BYPASS != 0) && wr_hit2) ? wr_data : regs_q[rd_addr2];
            rd_busy2 = busy_q[rd_addr2] && !((BYPASS != 0) && wr_hit2);
        end
    end

    // Release by a same-cycle writeback is visible to issue regardless of BYPASS.
    assign issue_ready = !is_real(issue_addr) || !busy_q[issue_addr] || wr_hit_iss;
    assign issue_take  = issue_en && issue_ready && is_real(issue_addr);

    // Write clears first, issue sets afterwards, so a same-address reservation wins.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wr_legal) begin
            regs_d[wr_addr] = wr_data;
            busy_d[wr_addr] = 1'b0;
        end
        if (issue_take) begin
            busy_d[issue_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench: two configurations driven in lockstep, checked against an array-based model.
module tb_regfile_scoreboard;
    typedef struct packed {
        logic [3:0] d1;
        logic [3:0] d2;
        logic       b1;
        logic       b2;
        logic       ir;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [3:0] wr_data;
    logic [1:0] rd_addr1, rd_addr2;
    logic       issue_en;
    logic [1:0] issue_addr;

    logic [3:0] rd_data1_0, rd_data2_0, rd_data1_1, rd_data2_1;
    logic       rd_busy1_0, rd_busy2_0, issue_ready_0;
    logic       rd_busy1_1, rd_busy2_1, issue_ready_1;

    int n_chk  = 0;
    int n_pass = 0;

    obs_t q0[$];
    obs_t q1[$];

    // Reference state, one copy per configuration (0: defaults, 1: ZERO_REG=1 BYPASS=0 NREGS=3).
    logic [3:0] mreg [2][4];
    logic       mbusy[2][4];

    always #5 clk = ~clk;

    regfile_scoreboard u_dut0 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(rd_data1_0), .rd_data2(rd_data2_0),
        .rd_busy1(rd_busy1_0), .rd_busy2(rd_busy2_0), .issue_en(issue_en),
        .issue_addr(issue_addr), .issue_ready(issue_ready_0)
    );

    regfile_scoreboard #(.DATA_W(4), .ADDR_W(2), .NREGS(3), .ZERO_REG(1), .BYPASS(0)) u_dut1 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(rd_data1_1), .rd_data2(rd_data2_1),
        .rd_busy1(rd_busy1_1), .rd_busy2(rd_busy2_1), .issue_en(issue_en),
        .issue_addr(issue_addr), .issue_ready(issue_ready_1)
    );

    function automatic int nregs_of(input int c);
        return (c == 0) ? 4 : 3;
    endfunction

    function automatic bit usable(input int c, input logic [1:0] a);
        if (int'(a) >= nregs_of(c)) return 1'b0;
        if (c == 1 && a == 2'd0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit same_cycle_write(input int c, input logic [1:0] a);
        return wr_en && usable(c, wr_addr) && wr_addr == a;
    endfunction

    function automatic logic [3:0] read_val(input int c, input logic [1:0] a);
        if (!usable(c, a)) return 4'h0;
        if (c == 0 && same_cycle_write(c, a)) return wr_data;
        return mreg[c][a];
    endfunction

    function automatic logic read_busy(input int c, input logic [1:0] a);
        if (!usable(c, a)) return 1'b0;
        if (c == 0 && same_cycle_write(c, a)) return 1'b0;
        return mbusy[c][a];
    endfunction

    function automatic logic ready_of(input int c);
        return !usable(c, issue_addr) || !mbusy[c][issue_addr] || same_cycle_write(c, issue_addr);
    endfunction

    function automatic obs_t predict(input int c);
        obs_t o;
        o.d1 = read_val(c, rd_addr1);
        o.d2 = read_val(c, rd_addr2);
        o.b1 = read_busy(c, rd_addr1);
        o.b2 = read_busy(c, rd_addr2);
        o.ir = ready_of(c);
        return o;
    endfunction

    task automatic model_step(input int c);
        logic rdy;
        if (reset) begin
            for (int r = 0; r < 4; r++) begin
                mreg[c][r]  = 4'h0;
                mbusy[c][r] = 1'b0;
            end
        end else begin
            rdy = ready_of(c);
            if (wr_en && usable(c, wr_addr)) begin
                mreg[c][wr_addr]  = wr_data;
                mbusy[c][wr_addr] = 1'b0;
            end
            if (issue_en && rdy && usable(c, issue_addr)) mbusy[c][issue_addr] = 1'b1;
        end
    endtask

    task automatic cycle(input bit rst, input bit we, input logic [1:0] wa, input logic [3:0] wd,
                         input logic [1:0] a1, input logic [1:0] a2,
                         input bit ie, input logic [1:0] ia);
        reset = rst; wr_en = we; wr_addr = wa; wr_data = wd;
        rd_addr1 = a1; rd_addr2 = a2; issue_en = ie; issue_addr = ia;
        q0.push_back(predict(0));
        q1.push_back(predict(1));
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    endtask

    always @(negedge clk) begin
        obs_t e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            chk("cfg0 rd_data1", rd_data1_0, e.d1);
            chk("cfg0 rd_data2", rd_data2_0, e.d2);
            chk("cfg0 rd_busy1", {3'b0, rd_busy1_0}, {3'b0, e.b1});
            chk("cfg0 rd_busy2", {3'b0, rd_busy2_0}, {3'b0, e.b2});
            chk("cfg0 issue_ready", {3'b0, issue_ready_0}, {3'b0, e.ir});
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            chk("cfg1 rd_data1", rd_data1_1, e.d1);
            chk("cfg1 rd_data2", rd_data2_1, e.d2);
            chk("cfg1 rd_busy1", {3'b0, rd_busy1_1}, {3'b0, e.b1});
            chk("cfg1 rd_busy2", {3'b0, rd_busy2_1}, {3'b0, e.b2});
            chk("cfg1 issue_ready", {3'b0, issue_ready_1}, {3'b0, e.ir});
        end
    end

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr1 = '0; rd_addr2 = '0; issue_en = 1'b0; issue_addr = '0;
        for (int c = 0; c < 2; c++)
            for (int r = 0; r < 4; r++) begin
                mreg[c][r]  = 4'h0;
                mbusy[c][r] = 1'b0;
            end
        repeat (2) @(posedge clk);
        #1;

        // reset state on every address
        cycle(0, 0, 0, 4'h0, 0, 1, 0, 0);
        cycle(0, 0, 0, 4'h0, 2, 3, 0, 3);
        // write, read back, same-cycle bypass versus old contents
        cycle(0, 1, 2, 4'hA, 0, 0, 0, 0);
        cycle(0, 1, 3, 4'h5, 2, 3, 0, 0);
        cycle(0, 0, 0, 4'h0, 2, 3, 0, 0);
        // reserve r1, refused second reservation, release by writeback
        cycle(0, 0, 0, 4'h0, 1, 1, 1, 1);
        cycle(0, 0, 0, 4'h0, 1, 1, 1, 1);
        cycle(0, 1, 1, 4'h7, 1, 1, 0, 1);
        cycle(0, 0, 0, 4'h0, 1, 1, 0, 1);
        // release and re-reserve of r1 in one cycle
        cycle(0, 0, 0, 4'h0, 1, 1, 1, 1);
        cycle(0, 1, 1, 4'h3, 1, 1, 1, 1);
        cycle(0, 0, 0, 4'h0, 1, 1, 0, 1);
        cycle(0, 1, 1, 4'h4, 1, 2, 0, 1);
        // register zero: write and issue
        cycle(0, 1, 0, 4'hF, 0, 1, 0, 0);
        cycle(0, 0, 0, 4'h0, 0, 1, 1, 0);
        cycle(0, 0, 0, 4'h0, 0, 2, 0, 0);
        // everything busy, pending write, then reset mid-operation
        for (int r = 0; r < 4; r++) cycle(0, 0, 0, 4'h0, 2'(r), 2, 1, 2'(r));
        cycle(0, 1, 2, 4'h9, 2, 3, 0, 0);
        cycle(1, 1, 1, 4'hF, 1, 2, 1, 3);
        cycle(0, 0, 0, 4'h0, 0, 1, 0, 2);
        cycle(0, 0, 0, 4'h0, 2, 3, 0, 3);
        // write to r3, unimplemented in the 3-register configuration
        cycle(0, 1, 3, 4'hC, 3, 3, 1, 3);
        cycle(0, 0, 0, 4'h0, 3, 2, 0, 3);

        for (int i = 0; i < 800; i++) begin
            cycle(($urandom_range(0, 63) == 0), $urandom_range(0, 1) != 0,
                  2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  $urandom_range(0, 1) != 0, 2'($urandom_range(0, 3)));
        end

        cycle(0, 0, 0, 4'h0, 0, 1, 0, 0);
        repeat (3) @(posedge clk);
        if (q0.size() != 0 || q1.size() != 0) begin
            n_chk++;
            $display("FAIL drain: %0d/%0d entries left, expected 0/0", q0.size(), q1.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
